// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_master
// Brief    : Single-channel AHB-Lite initiator turning a command/stream
//            interface into SINGLE/INCR bursts with wait, BUSY and ERROR support.
// Revision : 1.0
// ============================================================================
module ahb_lite_master #(
    parameter int         AW    = 32,
    parameter logic [3:0] HPROT = 4'b0011
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [3:0]    cmd_len,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [31:0]   wd_data,
    output logic          rd_valid,
    output logic [31:0]   rd_data,
    output logic          rd_last,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] haddr,
    output logic [1:0]    htrans,
    output logic          hwrite,
    output logic [2:0]    hsize,
    output logic [2:0]    hburst,
    output logic [3:0]    hprot,
    output logic [31:0]   hwdata,
    input  logic          hready,
    input  logic [31:0]   hrdata,
    input  logic          hresp
);

    localparam logic [1:0] c_HT_IDLE   = 2'b00;
    localparam logic [1:0] c_HT_BUSY   = 2'b01;
    localparam logic [1:0] c_HT_NONSEQ = 2'b10;
    localparam logic [1:0] c_HT_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_write;
    logic [AW-1:0]   r_addr;
    logic [2:0]      r_size;
    logic [3:0]      r_len;
    logic [3:0]      r_cnt;
    logic [3:0]      r_dcnt;
    logic            r_pending;
    logic [31:0]     r_hwdata;
    logic            r_rd_valid;
    logic [31:0]     r_rd_data;
    logic            r_rd_last;
    logic            r_done;
    logic            r_err;

    logic            w_hs;
    logic            w_dp_ok;
    logic            w_dp_err;
    logic            w_restart;
    logic            w_stall;
    logic            w_issue;
    logic [1:0]      w_htrans;
    logic [2:0]      w_size;
    logic [2:0]      w_step;
    logic [AW-1:0]   w_incr;
    logic            w_fin_ok;
    logic            w_fin_err;

    // cmd_ready stays low during the done cycle, giving one idle cycle between commands
    assign cmd_ready = (r_state == ST_IDLE) && !r_done && !rst;
    assign w_hs      = cmd_valid && cmd_ready;
    assign w_dp_ok   = r_pending && hready && !hresp;
    assign w_dp_err  = r_pending && hresp;
    assign w_restart = (r_cnt == 4'd0) || (r_addr[9:0] == 10'd0);
    assign w_stall   = r_write && !wd_valid;
    assign w_size    = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    assign w_step    = (r_size == 3'd0) ? 3'b001 : ((r_size == 3'd1) ? 3'b010 : 3'b100);
    assign w_incr    = {{(AW-3){1'b0}}, w_step};

    assign w_fin_ok  = (r_state == ST_DRAIN) && w_dp_ok;
    assign w_fin_err = (((r_state == ST_ISSUE) || (r_state == ST_DRAIN)) && w_dp_err && hready)
                     || ((r_state == ST_ERR) && hready);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_htrans = c_HT_IDLE;
        w_issue  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (w_stall) begin
                    w_htrans = (r_cnt == 4'd0) ? c_HT_IDLE : c_HT_BUSY;
                end else begin
                    w_htrans = w_restart ? c_HT_NONSEQ : c_HT_SEQ;
                end
                // an address presented while an ERROR is signalled is never accepted
                w_issue = hready && w_htrans[1] && !w_dp_err;
                if (w_dp_err) begin
                    w_next = hready ? ST_IDLE : ST_ERR;
                end else if (w_issue && (r_cnt == r_len)) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_dp_err) begin
                    w_next = hready ? ST_IDLE : ST_ERR;
                end else if (w_dp_ok) begin
                    w_next = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (hready) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_size     <= 3'd0;
            r_len      <= 4'd0;
            r_cnt      <= 4'd0;
            r_dcnt     <= 4'd0;
            r_pending  <= 1'b0;
            r_hwdata   <= 32'd0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 32'd0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done     <= w_fin_ok || w_fin_err;
            r_err      <= w_fin_err;
            r_rd_valid <= w_dp_ok && !r_write;
            r_rd_last  <= w_dp_ok && !r_write && (r_dcnt == r_len);
            if (w_dp_ok && !r_write) begin
                r_rd_data <= hrdata;
            end
            if (w_dp_ok) begin
                r_dcnt <= r_dcnt + 4'd1;
            end
            if (w_issue) begin
                r_pending <= 1'b1;
            end else if (hready) begin
                r_pending <= 1'b0;
            end
            if (w_hs) begin
                r_write <= cmd_write;
                r_addr  <= cmd_addr;
                r_size  <= w_size;
                r_len   <= cmd_len;
                r_cnt   <= 4'd0;
                r_dcnt  <= 4'd0;
            end else if (w_issue) begin
                r_addr <= r_addr + w_incr;
                r_cnt  <= r_cnt + 4'd1;
                if (r_write) begin
                    r_hwdata <= wd_data;
                end
            end
        end
    end

    assign wd_ready = r_write && hready && wd_valid && (r_state == ST_ISSUE) && !w_dp_err && !rst;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_last  = r_rd_last;
    assign done     = r_done;
    assign err      = r_err;
    assign haddr    = r_addr;
    assign htrans   = w_htrans;
    assign hwrite   = r_write;
    assign hsize    = r_size;
    assign hburst   = (r_len == 4'd0) ? 3'b000 : 3'b001;
    assign hprot    = HPROT;
    assign hwdata   = r_hwdata;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_master
// Brief    : Scoreboard bench for ahb_lite_master with a small AHB slave model.
// Revision : 1.0
// ============================================================================
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [2:0]  cmd_size = 3'd0;
    logic [3:0]  cmd_len = 4'd0;
    logic        wd_valid = 1'b0;
    logic        wd_ready;
    logic [31:0] wd_data = 32'd0;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic        hresp;

    int checks = 0;
    int failures = 0;

    ahb_lite_master #(.AW(32), .HPROT(4'b0011)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .hresp(hresp)
    );

    always #5 clk = ~clk;

    // Slave model: per-beat wait states and a two-cycle ERROR on a chosen beat
    logic        s_act = 1'b0;
    logic        s_wr = 1'b0;
    logic        s_err = 1'b0;
    logic        s_eph = 1'b0;
    logic [31:0] s_addr = 32'd0;
    int          s_wait = 0;
    int          s_beat = 0;
    int          wait_beat = -1;
    int          wait_n = 0;
    int          err_beat = -1;

    assign hready = !s_act || ((s_wait == 0) && (!s_err || s_eph));
    assign hresp  = s_act && (s_wait == 0) && s_err;
    assign hrdata = s_act ? (32'hC0DE_0000 ^ s_addr) : 32'd0;

    always @(posedge clk) begin
        if (rst) begin
            s_act <= 1'b0; s_wr <= 1'b0; s_err <= 1'b0; s_eph <= 1'b0;
            s_wait <= 0; s_beat <= 0;
        end else begin
            if (cmd_valid && cmd_ready) s_beat <= 0;
            if (s_act) begin
                if (s_wait > 0) s_wait <= s_wait - 1;
                else if (s_err && !s_eph) s_eph <= 1'b1;
                else s_act <= 1'b0;
            end
            if (hready && htrans[1]) begin
                s_act  <= 1'b1;
                s_addr <= haddr;
                s_wr   <= hwrite;
                s_wait <= (s_beat == wait_beat) ? wait_n : 0;
                s_err  <= (s_beat == err_beat);
                s_eph  <= 1'b0;
                s_beat <= s_beat + 1;
            end
        end
    end

    // Observations and expectations
    logic [33:0] obs_addr[$];
    logic [2:0]  obs_burst[$];
    logic [1:0]  obs_tr[$];
    logic [32:0] obs_rd[$];
    logic [63:0] obs_wr[$];
    logic        obs_done[$];
    int          obs_hs[$];
    logic [32:0] exp_rd[$];
    logic [63:0] exp_wr[$];
    logic [1:0]  exp_tr[$];

    int          cyc_n = 0;
    int          issue_cyc = 0;
    int          done_cyc = 0;
    int          n_wdr = 0;
    int          err2_seen = 0;
    int          err2_bad = 0;
    int          hold_bad = 0;
    logic        p_act = 1'b0;
    logic        p_rdy = 1'b1;
    logic [31:0] p_addr = 32'd0;
    logic        hs_seen = 1'b0;
    logic        wd_seen = 1'b0;
    logic        done_seen = 1'b0;
    logic [31:0] wd_base = 32'd0;

    task automatic clear_obs();
        obs_addr.delete(); obs_burst.delete(); obs_tr.delete(); obs_rd.delete();
        obs_wr.delete(); obs_done.delete(); obs_hs.delete();
        exp_rd.delete(); exp_wr.delete(); exp_tr.delete();
        n_wdr = 0; err2_seen = 0; err2_bad = 0; hold_bad = 0;
        wait_beat = -1; wait_n = 0; err_beat = -1;
    endtask

    // One clock cycle: settle, record what the bus and DUT show, advance past the edge
    task automatic step();
        #1;
        hs_seen   = cmd_valid && cmd_ready;
        wd_seen   = wd_ready;
        done_seen = done;
        if (hs_seen) obs_hs.push_back(cyc_n);
        if (hready && htrans[1]) begin
            if (obs_addr.size() == 0) issue_cyc = cyc_n;
            obs_addr.push_back({htrans, haddr});
            obs_burst.push_back(hburst);
        end
        if (htrans != 2'b00) obs_tr.push_back(htrans);
        if (wd_ready) n_wdr++;
        if (rd_valid) obs_rd.push_back({rd_last, rd_data});
        if (s_act && s_wr && hready && !hresp) obs_wr.push_back({s_addr, hwdata});
        if (hresp && hready) begin
            err2_seen++;
            if (htrans != 2'b00) err2_bad++;
        end
        if (p_act && !p_rdy && htrans[1] && (haddr !== p_addr)) hold_bad++;
        p_act = htrans[1]; p_rdy = hready; p_addr = haddr;
        if (done) begin
            obs_done.push_back(err);
            done_cyc = cyc_n;
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                           input logic [3:0] len, input int stall_beat, input int stall_n,
                           input int n_exp, input logic chain);
        int beat = 0;
        int left = stall_n;
        int n = 0;
        logic [31:0] a;
        for (int k = 0; k < n_exp; k++) begin
            a = addr + (32'(k) << size);
            if (wr) exp_wr.push_back({a, wd_base + 32'(k)});
            else    exp_rd.push_back({(k == int'(len)), 32'hC0DE_0000 ^ a});
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_len = len;
        done_seen = 1'b0;
        while (!done_seen && n < 200) begin
            wd_valid = wr && (beat <= int'(len)) && !((beat == stall_beat) && (left > 0));
            wd_data  = wd_base + 32'(beat);
            step();
            n++;
            if (hs_seen) begin
                if (chain) begin
                    cmd_write = 1'b0; cmd_addr = 32'h500; cmd_size = 3'd2; cmd_len = 4'd1;
                end else begin
                    cmd_valid = 1'b0;
                end
            end
            if (wd_seen) beat++;
            else if (!wd_valid && (beat == stall_beat) && (left > 0)) left--;
        end
        wd_valid = 1'b0;
        if (!done_seen) begin
            checks++; failures++;
            $display("FAIL cmd_timeout: addr %h got no done within %0d cycles", addr, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({htrans, haddr, hwdata} !== 66'd0) begin
            failures++; $display("FAIL reset_bus: htrans %b haddr %h hwdata %h want 0", htrans, haddr, hwdata);
        end
        checks++;
        if ({cmd_ready, wd_ready, rd_valid, done, err} !== 5'd0) begin
            failures++; $display("FAIL reset_ctrl: got %b want 00000", {cmd_ready, wd_ready, rd_valid, done, err});
        end
        checks++;
        if ({hwrite, hsize, hburst, rd_last, rd_data} !== 40'd0) begin
            failures++; $display("FAIL reset_misc: got %h want 0", {hwrite, hsize, hburst, rd_last, rd_data});
        end
        checks++;
        if (hprot !== 4'b0011) begin
            failures++; $display("FAIL reset_hprot: got %b want 0011", hprot);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
        end
        step();
    endtask

    task automatic test_single_write();
        logic [63:0] e, o;
        clear_obs();
        wd_base = 32'hA5A5_0001;
        run_cmd(1'b1, 32'h40, 3'd2, 4'd0, -1, 0, 1, 1'b0);
        checks++;
        if (obs_addr.size() != 1 || obs_addr[0] !== {2'b10, 32'h40}) begin
            failures++; $display("FAIL sw_addr: got %0d phases first %h want 1 phase %h", obs_addr.size(), obs_addr[0], {2'b10, 32'h40});
        end
        checks++;
        if (obs_burst[0] !== 3'b000) begin
            failures++; $display("FAIL sw_hburst: got %b want 000", obs_burst[0]);
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin
                failures++; $display("FAIL sw_wdata: got none want %h", e);
            end else begin
                o = obs_wr.pop_front();
                if (o !== e) begin failures++; $display("FAIL sw_wdata: got %h want %h", o, e); end
            end
        end
        checks++;
        if (done_cyc - issue_cyc != 2) begin
            failures++; $display("FAIL sw_done_latency: got %0d want 2", done_cyc - issue_cyc);
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] !== 1'b0) begin
            failures++; $display("FAIL sw_err: got %0d dones err %b want 1 done err 0", obs_done.size(), obs_done[0]);
        end
    endtask

    task automatic test_incr4_read();
        logic [32:0] e, o;
        logic [33:0] ea[4];
        clear_obs();
        wait_beat = 1; wait_n = 2;
        ea[0] = {2'b10, 32'h100}; ea[1] = {2'b11, 32'h104};
        ea[2] = {2'b11, 32'h108}; ea[3] = {2'b11, 32'h10C};
        run_cmd(1'b0, 32'h100, 3'd2, 4'd3, -1, 0, 4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_addr[i] !== ea[i]) begin
                failures++; $display("FAIL rd4_addr%0d: got %h want %h", i, obs_addr[i], ea[i]);
            end
        end
        checks++;
        if (obs_addr.size() != 4 || obs_burst[0] !== 3'b001) begin
            failures++; $display("FAIL rd4_phases: got %0d hburst %b want 4 hburst 001", obs_addr.size(), obs_burst[0]);
        end
        checks++;
        if (hold_bad != 0) begin
            failures++; $display("FAIL rd4_hold: got %0d address changes in waits want 0", hold_bad);
        end
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            checks++;
            if (obs_rd.size() == 0) begin
                failures++; $display("FAIL rd4_data: got none want %h", e);
            end else begin
                o = obs_rd.pop_front();
                if (o !== e) begin failures++; $display("FAIL rd4_data: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_rd.size() != 0) begin
            failures++; $display("FAIL rd4_extra: got %0d extra rd_valid want 0", obs_rd.size());
        end
    endtask

    task automatic test_busy_write();
        logic [63:0] e, o;
        logic [1:0]  et, ot;
        clear_obs();
        wd_base = 32'h0000_00B0;
        exp_tr.push_back(2'b10); exp_tr.push_back(2'b11); exp_tr.push_back(2'b01);
        exp_tr.push_back(2'b01); exp_tr.push_back(2'b10); exp_tr.push_back(2'b11);
        run_cmd(1'b1, 32'h3FE, 3'd0, 4'd3, 2, 2, 4, 1'b0);
        checks++;
        if (obs_tr.size() != 6) begin
            failures++; $display("FAIL busy_trace_len: got %0d want 6", obs_tr.size());
        end
        while (exp_tr.size() > 0 && obs_tr.size() > 0) begin
            et = exp_tr.pop_front(); ot = obs_tr.pop_front();
            checks++;
            if (ot !== et) begin failures++; $display("FAIL busy_htrans: got %b want %b", ot, et); end
        end
        checks++;
        if (n_wdr != 4) begin
            failures++; $display("FAIL busy_wd_ready: got %0d pulses want 4", n_wdr);
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin
                failures++; $display("FAIL busy_wdata: got none want %h", e);
            end else begin
                o = obs_wr.pop_front();
                if (o !== e) begin failures++; $display("FAIL busy_wdata: got %h want %h", o, e); end
            end
        end
    endtask

    task automatic test_error_read();
        logic [32:0] e, o;
        clear_obs();
        err_beat = 3;
        run_cmd(1'b0, 32'h200, 3'd2, 4'd7, -1, 0, 3, 1'b0);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            checks++;
            if (obs_rd.size() == 0) begin
                failures++; $display("FAIL err_rdata: got none want %h", e);
            end else begin
                o = obs_rd.pop_front();
                if (o !== e) begin failures++; $display("FAIL err_rdata: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_rd.size() != 0) begin
            failures++; $display("FAIL err_extra_rd: got %0d extra rd_valid want 0", obs_rd.size());
        end
        checks++;
        if (obs_addr.size() != 4) begin
            failures++; $display("FAIL err_phases: got %0d accepted addresses want 4", obs_addr.size());
        end
        checks++;
        if (err2_seen != 1 || err2_bad != 0) begin
            failures++; $display("FAIL err_htrans: got %0d second error cycles %0d non-idle want 1 and 0", err2_seen, err2_bad);
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] !== 1'b1) begin
            failures++; $display("FAIL err_done: got %0d dones err %b want 1 done err 1", obs_done.size(), obs_done[0]);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++; $display("FAIL err_ready: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ew, ow;
        logic [32:0] er, orr;
        int d1;
        clear_obs();
        wd_base = 32'h2222_0000;
        run_cmd(1'b1, 32'h480, 3'd2, 4'd1, -1, 0, 2, 1'b1);
        d1 = done_cyc;
        run_cmd(1'b0, 32'h500, 3'd2, 4'd1, -1, 0, 2, 1'b0);
        checks++;
        if (obs_hs.size() != 2 || obs_hs[1] != d1 + 1) begin
            failures++; $display("FAIL b2b_handshake: got %0d handshakes second at %0d want 2 at %0d", obs_hs.size(), obs_hs[1], d1 + 1);
        end
        while (exp_wr.size() > 0) begin
            ew = exp_wr.pop_front();
            checks++;
            if (obs_wr.size() == 0) begin
                failures++; $display("FAIL b2b_wdata: got none want %h", ew);
            end else begin
                ow = obs_wr.pop_front();
                if (ow !== ew) begin failures++; $display("FAIL b2b_wdata: got %h want %h", ow, ew); end
            end
        end
        while (exp_rd.size() > 0) begin
            er = exp_rd.pop_front();
            checks++;
            if (obs_rd.size() == 0) begin
                failures++; $display("FAIL b2b_rdata: got none want %h", er);
            end else begin
                orr = obs_rd.pop_front();
                if (orr !== er) begin failures++; $display("FAIL b2b_rdata: got %h want %h", orr, er); end
            end
        end
        checks++;
        if (obs_done.size() != 2 || obs_done[0] !== 1'b0 || obs_done[1] !== 1'b0) begin
            failures++; $display("FAIL b2b_done: got %0d dones want 2 without err", obs_done.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] e, o;
        int beat = 0;
        int n = 0;
        clear_obs();
        wd_base = 32'h1111_0000;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h600; cmd_size = 3'd2; cmd_len = 4'd3;
        while (obs_addr.size() < 2 && n < 20) begin
            wd_valid = 1'b1;
            wd_data  = wd_base + 32'(beat);
            step();
            n++;
            if (hs_seen) cmd_valid = 1'b0;
            if (wd_seen) beat++;
        end
        checks++;
        if (obs_addr.size() != 2) begin
            failures++; $display("FAIL rstmid_setup: got %0d accepted beats want 2", obs_addr.size());
        end
        wd_data = wd_base + 32'(beat);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wd_valid = 1'b0;
        #1;
        checks++;
        if ({htrans, haddr, hwdata} !== 66'd0) begin
            failures++; $display("FAIL rstmid_bus: htrans %b haddr %h hwdata %h want 0", htrans, haddr, hwdata);
        end
        checks++;
        if ({wd_ready, rd_valid, done, err, hwrite, hburst} !== 8'd0) begin
            failures++; $display("FAIL rstmid_ctrl: got %b want 0", {wd_ready, rd_valid, done, err, hwrite, hburst});
        end
        repeat (3) step();
        checks++;
        if (obs_done.size() != 0) begin
            failures++; $display("FAIL rstmid_done: got %0d done pulses want 0", obs_done.size());
        end
        clear_obs();
        run_cmd(1'b0, 32'h700, 3'd2, 4'd0, -1, 0, 1, 1'b0);
        while (exp_rd.size() > 0) begin
            e = exp_rd.pop_front();
            checks++;
            if (obs_rd.size() == 0) begin
                failures++; $display("FAIL rstmid_rdata: got none want %h", e);
            end else begin
                o = obs_rd.pop_front();
                if (o !== e) begin failures++; $display("FAIL rstmid_rdata: got %h want %h", o, e); end
            end
        end
        checks++;
        if (obs_done.size() != 1 || obs_done[0] !== 1'b0) begin
            failures++; $display("FAIL rstmid_after: got %0d dones want 1 without err", obs_done.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_incr4_read();
        test_busy_write();
        test_error_read();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-channel AHB-Lite initiator. Converts a simple command/stream interface into AHB-Lite transfers toward bus slaves such as the on-chip SRAM slave.
- Supports SINGLE and INCR bursts of 1..16 beats, slave wait states, write-data stalls (BUSY), 1KB-boundary restart, and two-cycle ERROR responses.
- Sits between a DMA/test engine and the AHB interconnect. One command is outstanding at a time.

Parameters:
AW, 32, address width of cmd_addr and haddr
HPROT, 4'b0011, constant value driven on hprot

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_addr  in  AW  start byte address, aligned to cmd_size
cmd_size  in  3  0=byte, 1=half, 2=word; values >2 treated as 2
cmd_len  in  4  beats minus 1 (0..15)
wd_valid  in  1  write-data beat available
wd_ready  out  1  write beat consumed
wd_data  in  32  write data, already placed on the correct byte lanes
rd_valid  out  1  read beat valid, one-cycle pulse, no backpressure
rd_data  out  32  read data
rd_last  out  1  final read beat of the command
done  out  1  one-cycle pulse at command completion
err  out  1  qualifies done: 1 = command terminated by ERROR
haddr  out  AW  AHB address
htrans  out  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  out  1  AHB direction
hsize  out  3  AHB size
hburst  out  3  000 SINGLE if cmd_len==0, else 001 INCR
hprot  out  4  =HPROT
hwdata  out  32  AHB write data, registered
hready  in  1  bus ready from interconnect
hrdata  in  32  AHB read data
hresp  in  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (rst=1 at edge): state IDLE. All outputs 0 (htrans=IDLE, haddr=0, hwdata=0); cmd_ready=0 while rst=1.
- FSM states: IDLE, ISSUE, DRAIN, ERR.
- IDLE:
  - cmd_ready=1, htrans=IDLE.
  - On handshake, latch write/addr/size/len, clear beat counter and error, go to ISSUE.
- ISSUE, address phase:
  - htrans=NONSEQ for beat 0 and for any beat whose address has bits [9:0]==0 (1KB restart); otherwise SEQ.
  - Write command with wd_valid=0: drive BUSY mid-burst, or IDLE for beat 0; haddr/hsize/hwrite are held.
  - A beat is issued at an edge where hready=1 and htrans is NONSEQ or SEQ.
  - On issue: haddr += (1<<size), counter++.
  - On issue of a write beat: wd_ready=1 combinationally (= write && hready && wd_valid && ISSUE && no error), and wd_data is registered into hwdata for the next cycle.
  - After the last beat issues, go to DRAIN with htrans=IDLE.
- Data phase:
  - A pending flag is set when a beat issues and cleared when hready=1.
  - Read beat completes (pending && hready && !hresp): the next cycle has rd_valid=1, rd_data=hrdata sampled, and rd_last=1 on beat cmd_len.
  - hwdata holds its value until its data phase completes.
  - Address and data phases overlap; there is no idle cycle between beats when wd_valid=1 and hready=1.
- DRAIN: when the final data phase completes, the next cycle has done=1, err=0, and the FSM returns to IDLE. The cycle after that, cmd_ready=1 (one-cycle gap between commands).
- ERROR handling:
  - Edge with pending && hresp=1 && hready=0: go to ERR. htrans=IDLE from the next cycle (the second error cycle); no further beats issue.
  - In ERR, when hready=1: done=1, err=1 next cycle, then IDLE.
  - The errored read beat produces no rd_valid.
  - Unissued write beats are not consumed; upstream flushes them.
- Simultaneous events:
  - A beat issue and a previous data-phase completion on the same edge are both honoured.
  - An ERROR seen while the next address phase is presented causes that address to be discarded (it was not accepted, because hready=0).
- rst mid-burst: immediate return to IDLE/outputs reset. The slave transfer in flight is abandoned; done is not pulsed.

Test Plan:
- Single write: addr=0x40, size=2, len=0, data 0xA5A5_0001, zero-wait slave -> one NONSEQ, hburst=000; hwdata=0xA5A5_0001 next cycle; done 2 cycles after issue, err=0.
- INCR4 read at 0x100 with 2 wait states on beat 1 -> haddr 0x100/104/108/10C, NONSEQ,SEQ,SEQ,SEQ; haddr is held during waits; 4 rd_valid pulses in order, rd_last only on the 4th.
- INCR4 byte write at 0x3FE with wd_valid low for 2 cycles before beat 2 -> htrans NONSEQ,SEQ,BUSY,BUSY,NONSEQ(0x400),SEQ; wd_ready pulses exactly 4 times.
- INCR8 read with ERROR on beat 3 -> htrans=IDLE in the second error cycle; only 3 rd_valid pulses; done=1 with err=1; cmd_ready returns.
- Back-to-back: write command then read command presented continuously -> second handshake the cycle after done; no overlap of commands.
- rst asserted during beat 2 of INCR4 -> the next cycle has htrans=IDLE and all outputs 0, with no done; a new command is then accepted normally.
